alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter OP_ADD, default 3'b010, ALU opcode for 8-bit add with carry-in.
REQ-002 Parameter OP_OTYPE, default 3'b111, ALU opcode selecting FUNC-decoded shift group.
REQ-003 Parameter FN_SHL_X/FN_SHL_O/FN_SHR_X/FN_SHR_O, defaults 3'b000/3'b010/3'b011/3'b101, shift FUNC codes (fill 0 / fill OVERFLOW_IN).
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 START  in  1  command request, sampled only in IDLE.
REQ-007 CMD  in  2  00 ADD16, 01 SUB16, 10 SHL16, 11 SHR16.
REQ-008 SRC_A, SRC_B  in  16 each  operands; SHAMT  in  4  shift count.
REQ-009 BUSY  out  1  high in every non-IDLE state; DONE  out  1  one-cycle completion pulse.
REQ-010 RESULT  out  16  registered result; FLAG, OVERFLOW  out  1 each  status registers.
REQ-011 ALU_A, ALU_B  out  8; ALU_OP, ALU_FUNC  out  3; ALU_FLAG_IN, ALU_OVF_IN  out  1  drive to ALU.
REQ-012 ALU_OUT  in  8; ALU_FLAG_OUT, ALU_OVF_OUT, ALU_FLAG_WR, ALU_OVF_WR  in  1  returned from combinational ALU.

Function
REQ-013 FSM states IDLE, LO, HI, DONE; IDLE+START -> LO (SHAMT==0 on shift -> DONE); LO -> HI; HI -> DONE, or -> LO if shift count remaining >0; DONE -> IDLE.
REQ-014 On accepted START: latch CMD, SRC_A into 16-bit work reg W, SRC_B into B reg, SHAMT into 4-bit down-counter.
REQ-015 START while BUSY ignored; no capture, no effect.
REQ-016 ADD16: LO issues OP_ADD, A=W[7:0], B=B[7:0], OVF_IN=0; HI issues OP_ADD, A=W[15:8], B=B[15:8], OVF_IN=OVERFLOW reg.
REQ-017 SUB16: identical to ADD16 but B operand bytes inverted and LO OVF_IN=1 (two's-complement A-B); ALU SUB opcode never issued.
REQ-018 SHL16 step: LO issues OP_OTYPE/FN_SHL_X on W[7:0]; HI issues FN_SHL_O on W[15:8] with OVF_IN=OVERFLOW reg (bit 7 of low byte).
REQ-019 SHR16 step: LO issues FN_SHR_X on W[15:8]; HI issues FN_SHR_O on W[7:0] with OVF_IN=OVERFLOW reg; counter decrements at end of HI.
REQ-020 Each LO/HI cycle writes ALU_OUT into the addressed byte of W.
REQ-021 OVERFLOW reg loads ALU_OVF_OUT when ALU_OVF_WR=1 in LO/HI; FLAG reg loads ALU_FLAG_OUT when ALU_FLAG_WR=1 in LO/HI; otherwise hold.
REQ-022 RESULT loads W on DONE entry; DONE high exactly one cycle; RESULT/FLAG/OVERFLOW hold until next command.
REQ-023 Latency START-to-DONE: ADD16/SUB16 3 cycles; shifts 2*SHAMT+1; SHAMT==0 -> 1 cycle, RESULT=SRC_A, OVERFLOW unchanged.
REQ-024 In IDLE/DONE all ALU_* outputs driven 0.
REQ-025 Final OVERFLOW = carry-out of ADD16, carry of SUB16 (1 = no borrow), last bit shifted out for shifts.

Reset
REQ-026 Reset at any cycle, including mid-command: state IDLE, W/B/counter/RESULT=0, FLAG=0, OVERFLOW=0, BUSY=0, DONE=0, ALU_* =0; Reset dominates START in same cycle.

Configuration
REQ-027 Macro ALU_SEQ_ZERO_FLAG_EN defined: on DONE entry FLAG loads (W==16'h0000), overriding REQ-021 for that cycle.
REQ-028 Macro absent: FLAG changes only per REQ-021; no zero detect logic present.

Verification
REQ-029 ADD16 A=16'h00FF, B=16'h0001 -> DONE 3 cycles after START, RESULT=16'h0100, OVERFLOW=0.
REQ-030 SUB16 A=16'h0000, B=16'h0001 -> RESULT=16'hFFFF, OVERFLOW=0; with ALU_SEQ_ZERO_FLAG_EN, SUB16 A=B=16'h1234 -> RESULT=0, FLAG=1.
REQ-031 SHL16 A=16'h8081, SHAMT=1 -> RESULT=16'h0102, OVERFLOW=1, DONE at cycle 3.
REQ-032 SHR16 A=16'h0003, SHAMT=15 -> RESULT=16'h0000, OVERFLOW=0, DONE at cycle 31; SHAMT=0 -> RESULT=SRC_A at cycle 1.
REQ-033 START pulsed while BUSY, then Reset asserted in HI -> second START ignored; next cycle IDLE, all outputs 0, new START accepted normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs 16-bit add/sub/shift commands as byte-wide steps on an
// external combinational 8-bit ALU, two ALU cycles (LO, HI) per step.
// Optional build macro: ALU_SEQ_ZERO_FLAG_EN -- FLAG takes (W == 0) on DONE entry.
module alu_sequencer #(
    parameter logic [2:0] OP_ADD   = 3'b010,
    parameter logic [2:0] OP_OTYPE = 3'b111,
    parameter logic [2:0] FN_SHL_X = 3'b000,
    parameter logic [2:0] FN_SHL_O = 3'b010,
    parameter logic [2:0] FN_SHR_X = 3'b011,
    parameter logic [2:0] FN_SHR_O = 3'b101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [15:0] src_a,
    input  logic [15:0] src_b,
    input  logic [3:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        flag,
    output logic        overflow,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_func,
    output logic        alu_flag_in,
    output logic        alu_ovf_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_flag_out,
    input  logic        alu_ovf_out,
    input  logic        alu_flag_wr,
    input  logic        alu_ovf_wr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] CMD_ADD = 2'd0;
    localparam logic [1:0] CMD_SUB = 2'd1;
    localparam logic [1:0] CMD_SHL = 2'd2;
    localparam logic [1:0] CMD_SHR = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [1:0]  cmd_q, cmd_nxt;
    logic [15:0] w, w_nxt;
    logic [15:0] b, b_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] result_nxt;
    logic        flag_nxt, overflow_nxt, busy_nxt, done_nxt;
    logic [7:0]  alu_a_nxt, alu_b_nxt;
    logic [2:0]  alu_op_nxt, alu_func_nxt;
    logic        alu_flag_in_nxt, alu_ovf_in_nxt;
    logic        wr_hi, nxt_hi, nxt_step;
    logic [7:0]  byte_w, byte_b;

    // State and all registered outputs; reset wins over any request
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_q       <= 2'd0;
            w           <= 16'd0;
            b           <= 16'd0;
            cnt         <= 4'd0;
            result      <= 16'd0;
            flag        <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alu_a       <= 8'd0;
            alu_b       <= 8'd0;
            alu_op      <= 3'd0;
            alu_func    <= 3'd0;
            alu_flag_in <= 1'b0;
            alu_ovf_in  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            w           <= w_nxt;
            b           <= b_nxt;
            cnt         <= cnt_nxt;
            result      <= result_nxt;
            flag        <= flag_nxt;
            overflow    <= overflow_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            alu_a       <= alu_a_nxt;
            alu_b       <= alu_b_nxt;
            alu_op      <= alu_op_nxt;
            alu_func    <= alu_func_nxt;
            alu_flag_in <= alu_flag_in_nxt;
            alu_ovf_in  <= alu_ovf_in_nxt;
        end
    end

    // Next state, datapath updates and next-cycle ALU drive
    always_comb begin
        state_nxt       = state;
        cmd_nxt         = cmd_q;
        w_nxt           = w;
        b_nxt           = b;
        cnt_nxt         = cnt;
        result_nxt      = result;
        flag_nxt        = flag;
        overflow_nxt    = overflow;
        alu_a_nxt       = 8'd0;
        alu_b_nxt       = 8'd0;
        alu_op_nxt      = 3'd0;
        alu_func_nxt    = 3'd0;
        alu_flag_in_nxt = 1'b0;
        alu_ovf_in_nxt  = 1'b0;
        // SHR works high byte first, everything else low byte first
        wr_hi           = (state == S_HI) ^ (cmd_q == CMD_SHR);
        nxt_hi          = 1'b0;
        nxt_step        = 1'b0;
        byte_w          = 8'd0;
        byte_b          = 8'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cmd_nxt   = cmd;
                    w_nxt     = src_a;
                    b_nxt     = src_b;
                    cnt_nxt   = shamt;
                    state_nxt = (cmd[1] && shamt == 4'd0) ? S_DONE : S_LO;
                end
            end
            S_LO, S_HI: begin
                if (wr_hi) w_nxt[15:8] = alu_out;
                else       w_nxt[7:0]  = alu_out;
                if (alu_ovf_wr)  overflow_nxt = alu_ovf_out;
                if (alu_flag_wr) flag_nxt     = alu_flag_out;
                if (state == S_LO) begin
                    state_nxt = S_HI;
                end else if (cmd_q[1]) begin
                    cnt_nxt   = cnt - 4'd1;
                    state_nxt = (cnt_nxt != 4'd0) ? S_LO : S_DONE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_DONE) begin
            result_nxt = w_nxt;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            flag_nxt   = (w_nxt == 16'h0000);
`endif
        end

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);

        nxt_step = (state_nxt == S_LO) || (state_nxt == S_HI);
        if (nxt_step) begin
            nxt_hi = (state_nxt == S_HI) ^ (cmd_nxt == CMD_SHR);
            byte_w = nxt_hi ? w_nxt[15:8] : w_nxt[7:0];
            byte_b = nxt_hi ? b_nxt[15:8] : b_nxt[7:0];
            alu_a_nxt       = byte_w;
            alu_flag_in_nxt = flag_nxt;
            case (cmd_nxt)
                CMD_ADD: begin
                    alu_op_nxt     = OP_ADD;
                    alu_b_nxt      = byte_b;
                    alu_ovf_in_nxt = (state_nxt == S_HI) ? overflow_nxt : 1'b0;
                end
                CMD_SUB: begin
                    alu_op_nxt     = OP_ADD;
                    alu_b_nxt      = ~byte_b;
                    alu_ovf_in_nxt = (state_nxt == S_HI) ? overflow_nxt : 1'b1;
                end
                CMD_SHL: begin
                    alu_op_nxt     = OP_OTYPE;
                    alu_func_nxt   = (state_nxt == S_HI) ? FN_SHL_O : FN_SHL_X;
                    alu_ovf_in_nxt = (state_nxt == S_HI) ? overflow_nxt : 1'b0;
                end
                default: begin
                    alu_op_nxt     = OP_OTYPE;
                    alu_func_nxt   = (state_nxt == S_HI) ? FN_SHR_O : FN_SHR_X;
                    alu_ovf_in_nxt = (state_nxt == S_HI) ? overflow_nxt : 1'b0;
                end
            endcase
        end
    end

endmodule
